// File: rtl/wb_arbiter_if.sv
// Writeback port bundle between pipeline, long-latency units, issue logic and the arbiter.
// The slave modport is the arbiter; the master modport is the driving environment.
interface wb_arbiter_if #(
  parameter int XLEN = 32
);
  logic            pipe_we;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_wd;
  logic            pipe_ready;

  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_wd;

  logic            iss_valid;
  logic [4:0]      iss_rd;

  logic            we3;
  logic [4:0]      a3;
  logic [XLEN-1:0] wd3;
  logic [31:0]     busy;
  logic            fifo_full;

  modport slave (
    input  pipe_we, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd, iss_valid, iss_rd,
    output pipe_ready, lu_ready, we3, a3, wd3, busy, fifo_full
  );

  modport master (
    output pipe_we, pipe_rd, pipe_wd, lu_valid, lu_rd, lu_wd, iss_valid, iss_rd,
    input  pipe_ready, lu_ready, we3, a3, wd3, busy, fifo_full
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and long-latency results into reg_file port 3, tracks pending dests.
// Latency: pipeline 1 cycle to we3; long-latency 2 cycles queued, 1 cycle bypassed when WB_BYPASS_EN is defined.
// Backpressure: pipe_ready/lu_ready drop while the FIFO is full; a full FIFO drains one entry per cycle.
module wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } wb_ent_t;

  typedef enum logic [1:0] {SRC_NONE, SRC_PIPE, SRC_FIFO, SRC_LU} src_e;

  wb_ent_t         fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            we3_q, we3_d;
  logic            ll_q, ll_d;
  logic [4:0]      a3_q, a3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [31:0]     busy_q, busy_d;

  logic            fifo_full, fifo_empty;
  logic            lu_fire, push, pop;
  src_e            src;
  wb_ent_t         head, pipe_ent, lu_ent, win;

  assign fifo_full  = (cnt_q == CW'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign lu_fire    = bus.lu_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr_q];
  assign pipe_ent   = {bus.pipe_rd, bus.pipe_wd};
  assign lu_ent     = {bus.lu_rd, bus.lu_wd};

  // A full FIFO outranks the pipeline so it can never be starved.
  always_comb begin
    src = SRC_NONE;
    if (fifo_full)                src = SRC_FIFO;
    else if (bus.pipe_we)         src = SRC_PIPE;
    else if (!fifo_empty)         src = SRC_FIFO;
    else if (BYPASS && lu_fire)   src = SRC_LU;
  end

  always_comb begin
    win = '0;
    case (src)
      SRC_PIPE: win = pipe_ent;
      SRC_FIFO: win = head;
      SRC_LU:   win = lu_ent;
      default:  win = '0;
    endcase
  end

  assign pop  = (src == SRC_FIFO);
  assign push = lu_fire && (src != SRC_LU);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // x0 winners are consumed but never raise we3.
  always_comb begin
    we3_d = 1'b0;
    ll_d  = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (src != SRC_NONE) begin
      we3_d = (win.rd != 5'd0);
      ll_d  = (src == SRC_FIFO) || (src == SRC_LU);
      a3_d  = win.rd;
      wd3_d = win.wd;
    end
  end

  // Clear on the edge where reg_file commits; a same-edge reissue keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    if (we3_q && ll_q)
      busy_d[a3_q] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0))
      busy_d[bus.iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      we3_q    <= 1'b0;
      ll_q     <= 1'b0;
      a3_q     <= '0;
      wd3_q    <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      we3_q    <= we3_d;
      ll_q     <= ll_d;
      a3_q     <= a3_d;
      wd3_q    <= wd3_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= lu_ent;
  end

  assign bus.pipe_ready = !fifo_full;
  assign bus.lu_ready   = !fifo_full;
  assign bus.we3        = we3_q;
  assign bus.a3         = a3_q;
  assign bus.wd3        = wd3_q;
  assign bus.busy       = busy_q;
  assign bus.fifo_full  = fifo_full;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: per-source ordered scoreboard plus per-scenario inline checks.
`timescale 1ns/1ps
module tb_wb_arbiter;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.XLEN(32)) bus ();

  wb_arbiter #(.XLEN(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

`ifdef WB_BYPASS_EN
  localparam int LU_LAT = 1;
`else
  localparam int LU_LAT = 2;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // {rd, wd} of writes expected on port 3, one queue per source so per-source order is enforced.
  logic [36:0] exp_pipe[$];
  logic [36:0] exp_lu[$];

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.we3 === 1'b1) begin
      tests_run++;
      if (exp_pipe.size() > 0 && exp_pipe[0] === {bus.a3, bus.wd3})
        void'(exp_pipe.pop_front());
      else if (exp_lu.size() > 0 && exp_lu[0] === {bus.a3, bus.wd3})
        void'(exp_lu.pop_front());
      else begin
        tests_failed++;
        $display("FAIL wb_order: got rd=%0d wd=%h, required head of pipe queue (%0d left) or lu queue (%0d left)",
                 bus.a3, bus.wd3, exp_pipe.size(), exp_lu.size());
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    bus.pipe_we   = 1'b0;
    bus.pipe_rd   = '0;
    bus.pipe_wd   = '0;
    bus.lu_valid  = 1'b0;
    bus.lu_rd     = '0;
    bus.lu_wd     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_rd    = '0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    tests_run++; if (bus.we3 !== 1'b0) begin tests_failed++; $display("FAIL reset_we3: got %b want 0", bus.we3); end
    tests_run++; if (bus.a3 !== 5'd0) begin tests_failed++; $display("FAIL reset_a3: got %0d want 0", bus.a3); end
    tests_run++; if (bus.wd3 !== 32'd0) begin tests_failed++; $display("FAIL reset_wd3: got %h want 0", bus.wd3); end
    tests_run++; if (bus.busy !== 32'd0) begin tests_failed++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
    tests_run++; if (bus.fifo_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    @(negedge clk);
    rst_n = 1'b1;
    sync();
    tests_run++; if (bus.pipe_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_pipe_ready: got %b want 1", bus.pipe_ready); end
    tests_run++; if (bus.lu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_lu_ready: got %b want 1", bus.lu_ready); end
  endtask

  task automatic test_pipe();
    bus.pipe_we = 1'b1;
    bus.pipe_rd = 5'd5;
    bus.pipe_wd = 32'hDEADBEEF;
    exp_pipe.push_back({5'd5, 32'hDEADBEEF});
    sync();
    idle();
    @(negedge clk);
    tests_run++; if (bus.we3 !== 1'b1) begin tests_failed++; $display("FAIL pipe_we3: got %b want 1", bus.we3); end
    tests_run++; if (bus.a3 !== 5'd5) begin tests_failed++; $display("FAIL pipe_a3: got %0d want 5", bus.a3); end
    tests_run++; if (bus.wd3 !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL pipe_wd3: got %h want deadbeef", bus.wd3); end
    @(negedge clk);
    tests_run++; if (bus.we3 !== 1'b0) begin tests_failed++; $display("FAIL pipe_we3_drop: got %b want 0", bus.we3); end
    sync();
  endtask

  task automatic test_lu_latency();
    int lat;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd7;
    sync();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.busy[7] !== 1'b1) begin tests_failed++; $display("FAIL lu_busy_set: got %b want 1", bus.busy[7]); end
    sync();
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd7;
    bus.lu_wd    = 32'h12345678;
    exp_lu.push_back({5'd7, 32'h12345678});
    sync();
    bus.lu_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.we3 !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    tests_run++; if (lat != LU_LAT) begin tests_failed++; $display("FAIL lu_latency: got %0d cycles want %0d", lat, LU_LAT); end
    tests_run++; if (bus.a3 !== 5'd7) begin tests_failed++; $display("FAIL lu_a3: got %0d want 7", bus.a3); end
    tests_run++; if (bus.busy[7] !== 1'b1) begin tests_failed++; $display("FAIL lu_busy_hold: got %b want 1", bus.busy[7]); end
    @(negedge clk);
    tests_run++; if (bus.busy[7] !== 1'b0) begin tests_failed++; $display("FAIL lu_busy_clear: got %b want 0", bus.busy[7]); end
    sync();
  endtask

  task automatic test_full();
    int  pi = 0;
    int  li = 0;
    bit  seen_full = 1'b0;
    bit  head_pending = 1'b0;
    for (int cyc = 0; cyc < 60 && (pi < 8 || li < 4); cyc++) begin
      bus.pipe_we  = (pi < 8);
      bus.pipe_rd  = 5'(10 + pi);
      bus.pipe_wd  = 32'hA000_0000 + 32'(pi);
      bus.lu_valid = (li < 4);
      bus.lu_rd    = 5'(20 + li);
      bus.lu_wd    = 32'hB000_0000 + 32'(li);
      @(negedge clk);
      if (head_pending) begin
        head_pending = 1'b0;
        tests_run++; if (bus.we3 !== 1'b1 || bus.a3 !== 5'd20) begin tests_failed++; $display("FAIL full_head_first: got we3=%b rd=%0d want we3=1 rd=20", bus.we3, bus.a3); end
      end
      if (bus.fifo_full === 1'b1 && !seen_full) begin
        seen_full    = 1'b1;
        head_pending = 1'b1;
        tests_run++; if (bus.pipe_ready !== 1'b0) begin tests_failed++; $display("FAIL full_pipe_ready: got %b want 0", bus.pipe_ready); end
        tests_run++; if (bus.lu_ready !== 1'b0) begin tests_failed++; $display("FAIL full_lu_ready: got %b want 0", bus.lu_ready); end
      end
      if (bus.pipe_we && bus.pipe_ready === 1'b1) begin
        exp_pipe.push_back({bus.pipe_rd, bus.pipe_wd});
        pi++;
      end
      if (bus.lu_valid && bus.lu_ready === 1'b1) begin
        exp_lu.push_back({bus.lu_rd, bus.lu_wd});
        li++;
      end
      sync();
    end
    idle();
    tests_run++; if (!seen_full) begin tests_failed++; $display("FAIL full_reached: got fifo_full never set want set"); end
    for (int n = 0; n < 30 && (exp_pipe.size() + exp_lu.size()) != 0; n++) @(negedge clk);
    tests_run++; if ((exp_pipe.size() + exp_lu.size()) != 0) begin tests_failed++; $display("FAIL full_drain: got %0d writes missing want 0", exp_pipe.size() + exp_lu.size()); end
    sync();
  endtask

  task automatic test_x0();
    bit we_seen = 1'b0;
    int lat;
    bus.pipe_we  = 1'b1;
    bus.pipe_rd  = 5'd0;
    bus.pipe_wd  = 32'hFFFFFFFF;
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd0;
    bus.lu_wd    = 32'hFFFFFFFF;
    sync();
    idle();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (bus.we3 === 1'b1) we_seen = 1'b1;
    end
    tests_run++; if (we_seen) begin tests_failed++; $display("FAIL x0_we3: got we3 asserted want never"); end
    tests_run++; if (bus.busy[0] !== 1'b0) begin tests_failed++; $display("FAIL x0_busy0: got %b want 0", bus.busy[0]); end
    tests_run++; if (bus.fifo_full !== 1'b0) begin tests_failed++; $display("FAIL x0_full: got %b want 0", bus.fifo_full); end
    sync();
    // An empty FIFO gives a lone lu result its minimum latency.
    bus.lu_valid = 1'b1;
    bus.lu_rd    = 5'd9;
    bus.lu_wd    = 32'h0000_0099;
    exp_lu.push_back({5'd9, 32'h0000_0099});
    sync();
    bus.lu_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.we3 !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    tests_run++; if (lat != LU_LAT || bus.a3 !== 5'd9) begin tests_failed++; $display("FAIL x0_fifo_empty: got lat=%0d rd=%0d want lat=%0d rd=9", lat, bus.a3, LU_LAT); end
    sync();
  endtask

  task automatic test_set_wins();
    int n;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    sync();
    bus.iss_valid = 1'b0;
    bus.lu_valid  = 1'b1;
    bus.lu_rd     = 5'd3;
    bus.lu_wd     = 32'h3333_3333;
    exp_lu.push_back({5'd3, 32'h3333_3333});
    sync();
    bus.lu_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(bus.we3 === 1'b1 && bus.a3 === 5'd3) && n < 8) begin
      @(negedge clk);
      n++;
    end
    tests_run++; if (n >= 8) begin tests_failed++; $display("FAIL setwins_commit: got no rd=3 write want one within 8 cycles"); end
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd3;
    sync();
    bus.iss_valid = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.busy[3] !== 1'b1) begin tests_failed++; $display("FAIL setwins_busy3: got %b want 1", bus.busy[3]); end
    sync();
  endtask

  task automatic test_reset_mid();
    bit we_seen = 1'b0;
    bus.iss_valid = 1'b1;
    bus.iss_rd    = 5'd12;
    sync();
    bus.iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pipe_we  = 1'b1;
      bus.pipe_rd  = 5'(24 + i);
      bus.pipe_wd  = 32'hC000_0000 + 32'(i);
      bus.lu_valid = 1'b1;
      bus.lu_rd    = 5'(28 + i);
      bus.lu_wd    = 32'hD000_0000 + 32'(i);
      exp_pipe.push_back({5'(24 + i), 32'hC000_0000 + 32'(i)});
      sync();
    end
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    exp_pipe.delete();
    exp_lu.delete();
    tests_run++; if (bus.we3 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_we3: got %b want 0", bus.we3); end
    tests_run++; if (bus.busy !== 32'd0) begin tests_failed++; $display("FAIL rstmid_busy: got %h want 0", bus.busy); end
    tests_run++; if (bus.fifo_full !== 1'b0) begin tests_failed++; $display("FAIL rstmid_full: got %b want 0", bus.fifo_full); end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.we3 === 1'b1) we_seen = 1'b1;
    end
    tests_run++; if (we_seen) begin tests_failed++; $display("FAIL rstmid_no_stale: got queued write after reset want none"); end
    sync();
  endtask

  initial begin
    idle();
    test_reset();
    test_pipe();
    test_lu_latency();
    test_full();
    test_x0();
    test_set_wins();
    test_reset_mid();
    tests_run++;
    if ((exp_pipe.size() + exp_lu.size()) != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_empty: got %0d outstanding want 0", exp_pipe.size() + exp_lu.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
